// File: rtl/tx_arbiter.sv
// Round-robin transmit arbiter: grants one message source per frame, handshakes with the encoder,
// and guards each frame with a timeout and an inter-frame gap. Define ARB_PRIO0_EN to give source 0 absolute priority.
module tx_arbiter #(
   parameter int N_SRC   = 38,
   parameter int TIMEOUT = 4096,
   parameter int GAP     = 2
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [N_SRC-1:0]         req,
   output logic [N_SRC-1:0]         grant,
   output logic [$clog2(N_SRC)-1:0] grant_id,
   output logic                     frame_start,
   input  logic                     frame_done,
   output logic                     busy,
   output logic                     timeout_err
);

   localparam int IDW = $clog2(N_SRC);
   localparam logic [15:0] TO_LAST  = 16'(TIMEOUT - 1);
   localparam logic [7:0]  GAP_LAST = 8'(GAP - 1);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ARB,
      ST_START,
      ST_WAIT,
      ST_GAP
   } state_t;

   state_t           state_q, state_d;
   logic [N_SRC-1:0] grant_q, grant_d;
   logic [IDW-1:0]   gid_q, gid_d;
   logic [IDW-1:0]   ptr_q, ptr_d;
   logic [15:0]      cnt_q, cnt_d;
   logic [7:0]       gap_cnt_q, gap_cnt_d;

   logic [IDW-1:0]   cand;
   logic             cand_found;
   logic             prio_win;
   logic [IDW-1:0]   win_idx;

`ifdef ARB_PRIO0_EN
   assign prio_win = req[0];
`else
   assign prio_win = 1'b0;
`endif

   // Round-robin search starting just above the last winner, wrapping to 0.
   always_comb begin
      cand       = '0;
      cand_found = 1'b0;
      for (int i = 0; i < N_SRC; i++) begin
         if (!cand_found) begin
            cand = IDW'((int'(ptr_q) + 1 + i) % N_SRC);
            cand_found = req[cand];
         end
      end
   end

   assign win_idx = prio_win ? '0 : cand;

   // NOTE: every variable gets a default before the case so no path can hold a value, which would infer a latch.
   always_comb begin
      state_d     = state_q;
      grant_d     = grant_q;
      gid_d       = gid_q;
      ptr_d       = ptr_q;
      cnt_d       = cnt_q;
      gap_cnt_d   = gap_cnt_q;
      timeout_err = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (|req) state_d = ST_ARB;
         end
         ST_ARB: begin
            if (|req) begin
               state_d = ST_START;
               grant_d = {{(N_SRC-1){1'b0}}, 1'b1} << win_idx;
               gid_d   = win_idx;
               if (!prio_win) ptr_d = win_idx;
            end else begin
               state_d = ST_IDLE;
               grant_d = '0;
            end
         end
         ST_START: begin
            state_d = ST_WAIT;
            cnt_d   = '0;
         end
         ST_WAIT: begin
            cnt_d = cnt_q + 16'd1;
            // frame_done takes precedence over a timeout landing in the same cycle.
            if (frame_done || cnt_q == TO_LAST) begin
               timeout_err = !frame_done;
               grant_d     = '0;
               cnt_d       = '0;
               gap_cnt_d   = '0;
               state_d     = (GAP == 0) ? ST_IDLE : ST_GAP;
            end
         end
         ST_GAP: begin
            if (gap_cnt_q == GAP_LAST) begin
               state_d   = ST_IDLE;
               gap_cnt_d = '0;
            end else begin
               gap_cnt_d = gap_cnt_q + 8'd1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so all of them update together at the edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         grant_q   <= '0;
         gid_q     <= '0;
         ptr_q     <= IDW'(N_SRC - 1);
         cnt_q     <= '0;
         gap_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         grant_q   <= grant_d;
         gid_q     <= gid_d;
         ptr_q     <= ptr_d;
         cnt_q     <= cnt_d;
         gap_cnt_q <= gap_cnt_d;
      end
   end

   assign grant       = grant_q;
   assign grant_id    = gid_q;
   assign frame_start = (state_q == ST_START);
   assign busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_tx_arbiter.sv
// Self-checking bench for tx_arbiter (N_SRC=4, TIMEOUT=16, GAP=2): directed scenarios plus
// randomized frames compared against a transaction-level round-robin model.
module tb_tx_arbiter;

   localparam int N  = 4;
   localparam int TO = 16;
   localparam int GP = 2;

   logic         clk = 1'b0;
   logic         rst;
   logic [N-1:0] req;
   logic [N-1:0] grant;
   logic [1:0]   grant_id;
   logic         frame_start;
   logic         frame_done;
   logic         busy;
   logic         timeout_err;

   int n_checks = 0;
   int n_err    = 0;
   int ptr_m    = N - 1;

   always #5 clk = ~clk;

   tx_arbiter #(.N_SRC(N), .TIMEOUT(TO), .GAP(GP)) dut (
      .clk         (clk),
      .rst         (rst),
      .req         (req),
      .grant       (grant),
      .grant_id    (grant_id),
      .frame_start (frame_start),
      .frame_done  (frame_done),
      .busy        (busy),
      .timeout_err (timeout_err)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Next winner: first requester above the last winner, wrapping around.
   function automatic int pick(input int last, input logic [N-1:0] r);
`ifdef ARB_PRIO0_EN
      if (r[0]) return 0;
`endif
      for (int i = 1; i <= N; i++)
         if (r[(last + i) % N]) return (last + i) % N;
      return -1;
   endfunction

   // Entered in an IDLE cycle; leaves in the IDLE cycle after the gap.
   // done_k: WAIT cycle index carrying frame_done (>= TO means never sent).
   task automatic do_frame(input logic [N-1:0] r, input int done_k);
      int win;
      int last_k;
      win = pick(ptr_m, r);
`ifdef ARB_PRIO0_EN
      if (!r[0]) ptr_m = win;
`else
      ptr_m = win;
`endif
      req = r;
      check("idle_busy", busy, 0);
      tick();
      check("arb_busy", busy, 1);
      check("arb_fs", frame_start, 0);
      tick();
      check("start_fs", frame_start, 1);
      check("start_grant", grant, 1 << win);
      check("start_gid", grant_id, win);
      last_k = (done_k < TO) ? done_k : TO - 1;
      for (int k = 0; k <= last_k; k++) begin
         tick();
         req = N'($urandom);
         if (k == done_k) begin
            frame_done = 1'b1;
            #1;
         end
         check("wait_fs", frame_start, 0);
         check("wait_grant", grant, 1 << win);
         check("wait_gid", grant_id, win);
         check("wait_timeout", timeout_err, (k == TO - 1 && k != done_k));
      end
      tick();
      frame_done = 1'b0;
      check("gap_grant", grant, 0);
      check("gap_gid", grant_id, win);
      check("gap_busy", busy, 1);
      check("gap_timeout", timeout_err, 0);
      for (int g = 1; g < GP; g++) begin
         tick();
         check("gap_busy", busy, 1);
         check("gap_grant", grant, 0);
      end
      tick();
      check("back_idle", busy, 0);
      check("idle_fs", frame_start, 0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int exp_seq[4] = '{1, 3, 1, 3};
      rst        = 1'b1;
      req        = '0;
      frame_done = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_grant", grant, 0);
      check("rst_gid", grant_id, 0);
      check("rst_fs", frame_start, 0);
      check("rst_busy", busy, 0);
      check("rst_timeout", timeout_err, 0);
      rst = 1'b0;
      tick();

      // Alternating round robin between sources 1 and 3.
      for (int i = 0; i < 4; i++) begin
         do_frame(4'b1010, 2);
         check("rr_seq", grant_id, exp_seq[i]);
      end

      // Encoder never answers: timeout path.
      do_frame(4'b0100, 100);
      // frame_done on the final counter cycle.
      do_frame(4'b0011, TO - 1);

      // Spurious frame_done while idle.
      req        = '0;
      frame_done = 1'b1;
      tick();
      frame_done = 1'b0;
      check("spur_busy", busy, 0);
      check("spur_grant", grant, 0);
      check("spur_timeout", timeout_err, 0);
      tick();
      check("spur_busy2", busy, 0);
      do_frame(4'b0001, 1);

      // Request withdrawn during arbitration.
      req = 4'b0110;
      tick();
      check("abort_arb_busy", busy, 1);
      req = '0;
      tick();
      check("abort_busy", busy, 0);
      check("abort_grant", grant, 0);
      check("abort_fs", frame_start, 0);
      do_frame(4'b1111, 0);

`ifdef ARB_PRIO0_EN
      for (int i = 0; i < 3; i++) do_frame(4'b1101, 1);
      do_frame(4'b1100, 1);
      do_frame(4'b1100, 1);
`endif

      // Reset asserted mid-WAIT.
      req = 4'b0010;
      tick();
      tick();
      check("pre_rst_grant", grant, 4'b0010);
      tick();
      tick();
      #2;
      rst = 1'b1;
      #1;
      check("midrst_grant", grant, 0);
      check("midrst_busy", busy, 0);
      check("midrst_gid", grant_id, 0);
      check("midrst_fs", frame_start, 0);
      tick();
      rst   = 1'b0;
      ptr_m = N - 1;
      do_frame(4'b1111, 3);

      // Randomized frames.
      for (int i = 0; i < 40; i++)
         do_frame(N'($urandom_range(1, 15)), $urandom_range(0, 18));

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
